// File: rtl/template_matcher.sv
// template_matcher: scores one stored binary character against NUM_TPL binary templates
// by pixel agreement count and reports the best template, its score and a threshold flag.
module template_matcher #(
   parameter int PIX_COUNT = 1024,
   parameter int NUM_TPL   = 16,
   parameter int RD_LAT    = 1,
   parameter int THRESH    = 800,
   localparam int SCORE_W  = $clog2(PIX_COUNT + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               char_pix,
   input  logic               tpl_pix,
   output logic               rd_en,
   output logic [15:0]        pix_addr,
   output logic [3:0]         tpl_sel,
   output logic               busy,
   output logic               done,
   output logic [3:0]         best_idx,
   output logic [SCORE_W-1:0] best_score,
   output logic               match_ok
);
   typedef enum logic [2:0] {IDLE, SCAN, DRAIN, CMP, DONE} state_t;
   state_t state, state_nx;
   logic [SCORE_W-1:0] score, cand;
   logic [RD_LAT-1:0] dly;
   logic [1:0] drain_cnt;
   logic accept, last_pix, last_drain, last_tpl, take, agree;
   assign accept     = state == IDLE && start;
   assign last_pix   = pix_addr == 16'(PIX_COUNT - 1);
   assign last_drain = drain_cnt == 2'(RD_LAT - 1);
   assign last_tpl   = tpl_sel == 4'(NUM_TPL - 1);
   // template 0 always loads; later ones only on a strict win so ties keep the lower index
   assign take       = tpl_sel == 4'd0 || score > best_score;
   assign cand       = take ? score : best_score;
   assign agree      = dly[RD_LAT-1] && char_pix == tpl_pix && score != SCORE_W'(PIX_COUNT);
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      rd_en = 1'b0;
      busy = 1'b0;
      done = 1'b0;
      case (state)
         IDLE:  state_nx = start ? SCAN : IDLE;
         SCAN:  begin rd_en = 1'b1; busy = 1'b1; state_nx = last_pix ? DRAIN : SCAN; end
         DRAIN: begin busy = 1'b1; state_nx = last_drain ? CMP : DRAIN; end
         CMP:   begin busy = 1'b1; state_nx = last_tpl ? DONE : SCAN; end
         DONE:  begin done = 1'b1; state_nx = IDLE; end
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         pix_addr <= '0;
         tpl_sel <= '0;
         score <= '0;
         dly <= '0;
         drain_cnt <= '0;
         best_idx <= '0;
         best_score <= '0;
         match_ok <= 1'b0;
      end else begin
         dly[0] <= rd_en;
         for (int i = 1; i < RD_LAT; i++) dly[i] <= dly[i-1];
         drain_cnt <= state == DRAIN ? drain_cnt + 2'd1 : 2'd0;
         if (accept || state == CMP) score <= '0;
         else if (agree) score <= score + 1'b1;
         if (accept) begin
            pix_addr <= '0;
            tpl_sel <= '0;
         end else if (state == SCAN && !last_pix) begin
            pix_addr <= pix_addr + 16'd1;
         end else if (state == CMP && !last_tpl) begin
            pix_addr <= '0;
            tpl_sel <= tpl_sel + 4'd1;
         end
         if (state == CMP && take) begin
            best_idx <= tpl_sel;
            best_score <= score;
         end
         if (state == CMP && last_tpl) match_ok <= int'(cand) >= THRESH;
      end
endmodule

// File: tb/tb_template_matcher.sv
// tb_template_matcher: two matchers (read latency 1 and 3) share the pixel stores; each output
// is checked every cycle against a frame-level schedule and score model, plus literal results.
module tb_template_matcher;
   localparam int PIX = 16, N = 4, TH = 12, SW = $clog2(PIX + 1);
   logic clk = 1'b0, rst_n = 1'b1;
   logic [1:0] start = '0;
   logic [PIX-1:0] char_mem;
   logic [PIX-1:0] tpl_mem [N];
   logic cpix [2], tpix [2], rd_en_v [2], busy_v [2], done_v [2], ok_v [2];
   logic [15:0] addr_v [2];
   logic [3:0] tsel_v [2], bidx_v [2];
   logic [SW-1:0] bscore_v [2];
   int done_cnt [2] = '{0, 0};
   int rdc [2] = '{0, 0};
   int vectors = 0, miscompares = 0;
   always #5 clk = ~clk;
   task automatic chk(input string nm, input int g, input logic [31:0] a, input logic [31:0] e);
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s lat%0d: got %0d, want %0d at %0t", nm, g ? 3 : 1, a, e, $time);
      end
   endtask
   // best template among the first c, returned as idx*256 + score
   function automatic int best_of(input int c);
      int bi = 0, bs = -1, s;
      for (int t = 0; t < c; t++) begin
         s = 0;
         for (int i = 0; i < PIX; i++) if (char_mem[i] == tpl_mem[t][i]) s++;
         if (s > bs) begin bs = s; bi = t; end
      end
      return bi * 256 + bs;
   endfunction
   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int L = g ? 3 : 1;
      localparam int P = PIX + L + 1;
      localparam int DJ = N * P;
      logic pv [L];
      logic [15:0] pa [L];
      logic [3:0] pt [L];
      logic [1:0] noise;
      logic act, prev_ok, run_on;
      int j, prev_b, ia, it, w, c, b;
      template_matcher #(.PIX_COUNT(PIX), .NUM_TPL(N), .RD_LAT(L), .THRESH(TH)) dut (
         .clk(clk), .reset(rst_n), .start(start[g]), .char_pix(cpix[g]), .tpl_pix(tpix[g]),
         .rd_en(rd_en_v[g]), .pix_addr(addr_v[g]), .tpl_sel(tsel_v[g]), .busy(busy_v[g]),
         .done(done_v[g]), .best_idx(bidx_v[g]), .best_score(bscore_v[g]), .match_ok(ok_v[g]));
      // synchronous stores with L-cycle latency; random pixels whenever no read is returning
      always @(posedge clk) begin
         noise <= 2'($urandom);
         pv[0] <= rd_en_v[g];
         pa[0] <= addr_v[g];
         pt[0] <= tsel_v[g];
         for (int i = 1; i < L; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
            pt[i] <= pt[i-1];
         end
      end
      assign cpix[g] = pv[L-1] ? char_mem[pa[L-1][3:0]] : noise[0];
      assign tpix[g] = pv[L-1] ? tpl_mem[pt[L-1][1:0]][pa[L-1][3:0]] : noise[1];
      // j counts edges since the accepting edge; a character occupies N frames of P cycles
      always @(posedge clk or negedge rst_n)
         if (!rst_n) begin
            act <= 1'b0; j <= 0; prev_b <= 0; prev_ok <= 1'b0; ia <= 0; it <= 0;
         end else if (act && j == DJ) begin
            act <= 1'b0;
            prev_b <= best_of(N);
            prev_ok <= best_of(N) % 256 >= TH;
            ia <= PIX - 1;
            it <= N - 1;
         end else if (act) begin
            j <= j + 1;
         end else if (start[g]) begin
            act <= 1'b1;
            j <= 0;
         end
      always @(negedge clk)
         if (!rst_n) begin
            chk("rst_busy", g, 32'(busy_v[g]), 0);
            chk("rst_rd_en", g, 32'(rd_en_v[g]), 0);
            chk("rst_done", g, 32'(done_v[g]), 0);
            chk("rst_best_idx", g, 32'(bidx_v[g]), 0);
            chk("rst_best_score", g, 32'(bscore_v[g]), 0);
            chk("rst_match_ok", g, 32'(ok_v[g]), 0);
         end else begin
            w = j % P;
            c = j / P;
            run_on = act && j < DJ;
            b = act && c > 0 ? best_of(c) : prev_b;
            chk("busy", g, 32'(busy_v[g]), 32'(run_on));
            chk("done", g, 32'(done_v[g]), 32'(act && j == DJ));
            chk("rd_en", g, 32'(rd_en_v[g]), 32'(run_on && w < PIX));
            if (run_on && w < PIX) begin
               chk("pix_addr", g, 32'(addr_v[g]), 32'(w));
               chk("tpl_sel", g, 32'(tsel_v[g]), 32'(c));
            end
            if (!act) begin
               chk("idle_addr", g, 32'(addr_v[g]), 32'(ia));
               chk("idle_tpl", g, 32'(tsel_v[g]), 32'(it));
            end
            chk("best_idx", g, 32'(bidx_v[g]), 32'(b / 256));
            chk("best_score", g, 32'(bscore_v[g]), 32'(b % 256));
            chk("match_ok", g, 32'(ok_v[g]), 32'(act && j == DJ ? b % 256 >= TH : prev_ok));
            done_cnt[g] += 32'(done_v[g]);
            rdc[g] += 32'(rd_en_v[g]);
         end
   end
   task automatic run(input logic [15:0] ch, t0, t1, t2, t3, input bit poke, input int abort,
                      input int ei, input int es, input int eo);
      int d0, d1, r0, r1, at0, at1;
      char_mem = ch;
      tpl_mem[0] = t0; tpl_mem[1] = t1; tpl_mem[2] = t2; tpl_mem[3] = t3;
      d0 = done_cnt[0]; d1 = done_cnt[1]; r0 = rdc[0]; r1 = rdc[1];
      at0 = -1; at1 = -1;
      @(negedge clk);
      start = 2'b11;
      for (int o = 0; o < 86; o++) begin
         @(negedge clk);
         if (done_v[0]) at0 = o;
         if (done_v[1]) at1 = o;
         start[0] = poke && (o == 10 || o == N * (PIX + 2));
         start[1] = poke && (o == 10 || o == N * (PIX + 4));
         if (o == abort) begin
            start = '0;
            #2 rst_n = 1'b0;
            #1;
            for (int g = 0; g < 2; g++) begin
               chk("abort_busy", g, 32'(busy_v[g]), 0);
               chk("abort_rd_en", g, 32'(rd_en_v[g]), 0);
               chk("abort_best_idx", g, 32'(bidx_v[g]), 0);
               chk("abort_best_score", g, 32'(bscore_v[g]), 0);
               chk("abort_match_ok", g, 32'(ok_v[g]), 0);
            end
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            break;
         end
      end
      start = '0;
      chk("done_count", 0, 32'(done_cnt[0] - d0), abort < 0 ? 1 : 0);
      chk("done_count", 1, 32'(done_cnt[1] - d1), abort < 0 ? 1 : 0);
      if (abort < 0) begin
         chk("done_cycle", 0, 32'(at0), 72);
         chk("done_cycle", 1, 32'(at1), 80);
         chk("rd_en_total", 0, 32'(rdc[0] - r0), 64);
         chk("rd_en_total", 1, 32'(rdc[1] - r1), 64);
         for (int g = 0; g < 2; g++) begin
            chk("lit_best_idx", g, 32'(bidx_v[g]), 32'(ei));
            chk("lit_best_score", g, 32'(bscore_v[g]), 32'(es));
            chk("lit_match_ok", g, 32'(ok_v[g]), 32'(eo));
         end
      end
   endtask
   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      run(16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, -1, 2, 16, 1);
      run(16'hA5C3, 16'hA5C3 ^ 16'hFFE0, 16'hA5C3 ^ 16'h0007, 16'hA5C3 ^ 16'h7FF0,
          16'hA5C3 ^ 16'h8101, 1'b0, -1, 1, 13, 1);
      run(16'h1234, 16'h1234 ^ 16'h001F, 16'h1234 ^ 16'h03F0, ~16'h1234,
          16'h1234 ^ 16'hF0F0, 1'b0, -1, 0, 11, 0);
      run(16'hF00F, 16'hF00E, 16'hF00F, 16'hF00F, 16'h0FF0, 1'b1, -1, 1, 16, 1);
      run(16'h3C5A, 16'h3C5A ^ 16'h0300, 16'h3C5A ^ 16'h00FF, 16'h3C5A, 16'h3C5A, 1'b0, 45, 0, 0, 0);
      run(16'h3C5A, 16'h3C5A ^ 16'h0300, 16'h3C5A ^ 16'h00FF, 16'h3C5A, 16'h3C5A, 1'b0, -1, 2, 16, 1);
      run(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, -1, 0, 16, 1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
